// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 decode constants, ALU operation enum and ID/EX control bundle.
//   OP_*     : primary opcode values accepted by the ID stage
//   FN_*     : R-type funct values accepted by the ID stage
//   alu_op_e : ALU operation code carried to EX
//   ctrl_t   : ID/EX control bundle, CTRL_W bits wide
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5
    } alu_op_e;
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
    } ctrl_t;
    localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/register_file.sv
// register_file: 32x32 register file, two async read ports with write-through bypass, one sync write port.
//   clk, reset           : clock, synchronous active-high clear of all registers
//   rs_addr_i, rt_addr_i : read addresses
//   rs_data_o, rt_data_o : read data; r0 reads 0, a same-cycle write to the address is returned
//   we_i, waddr_i, wdata_i : write port, writes to r0 are dropped
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] regs_q [32];
    assign rs_data_o = rs_addr_i == 5'd0 ? 32'd0 : (we_i && rs_addr_i == waddr_i) ? wdata_i : regs_q[rs_addr_i];
    assign rt_data_o = rt_addr_i == 5'd0 ? 32'd0 : (we_i && rt_addr_i == waddr_i) ? wdata_i : regs_q[rt_addr_i];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: MIPS32 ID stage with register file, load-use hazard detection and ID/EX register.
//   clk, reset                 : clock, synchronous active-high reset
//   if_id_instr, if_id_pc      : instruction and PC from IF/ID
//   wb_we, wb_addr, wb_data    : register-file write port driven by WB
//   stall                      : combinational load-use hazard, IF/ID must hold while high
//   illegal                    : current ID/EX slot came from an unsupported instruction
//   id_ex_*                    : ID/EX pipeline register contents
module instruction_decode
    import mips_pkg::*;
#(
    parameter int WARMUP = 2,
    parameter int PC_W   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     if_id_instr,
    input  logic [PC_W-1:0] if_id_pc,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            stall,
    output logic            illegal,
    output logic            id_ex_valid,
    output logic [PC_W-1:0] id_ex_pc,
    output logic [31:0]     id_ex_rs_data,
    output logic [31:0]     id_ex_rt_data,
    output logic [31:0]     id_ex_imm,
    output logic [4:0]      id_ex_shamt,
    output logic [4:0]      id_ex_rs,
    output logic [4:0]      id_ex_rt,
    output logic [4:0]      id_ex_dest,
    output logic [3:0]      id_ex_alu_op,
    output logic            id_ex_alu_src,
    output logic            id_ex_reg_write,
    output logic            id_ex_mem_read,
    output logic            id_ex_mem_write,
    output logic            id_ex_mem_to_reg
);
    localparam int CW = $clog2(WARMUP + 2);
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm_d;
    ctrl_t ctrl_d, ctrl_s;
    logic [4:0] dest_d;
    logic legal_d, reads_rt, accept, launch;
    logic [CW-1:0] warm_q;
    logic valid_q, illegal_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0] shamt_q, rs_q, rt_q, dest_q;
    logic [CTRL_W-1:0] ctrl_q;
    assign opcode = if_id_instr[31:26];
    assign rs     = if_id_instr[25:21];
    assign rt     = if_id_instr[20:16];
    assign rd     = if_id_instr[15:11];
    assign funct  = if_id_instr[5:0];
    assign imm_d  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    register_file u_rf (
        .clk       (clk),
        .reset     (reset),
        .rs_addr_i (rs),
        .rt_addr_i (rt),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );
    always_comb begin
        ctrl_d  = '0;
        dest_d  = '0;
        legal_d = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal_d = 1'b1;
                ctrl_d.reg_write = 1'b1;
                dest_d = rd;
                case (funct)
                    FN_ADD:  ctrl_d.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_d.alu_op = ALU_SUB;
                    FN_AND:  ctrl_d.alu_op = ALU_AND;
                    FN_OR:   ctrl_d.alu_op = ALU_OR;
                    FN_SLT:  ctrl_d.alu_op = ALU_SLT;
                    FN_SLL:  ctrl_d.alu_op = ALU_SLL;
                    default: legal_d = 1'b0;
                endcase
            end
            OP_ADDI: begin
                legal_d = 1'b1;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.reg_write = 1'b1;
                dest_d = rt;
            end
            OP_LW: begin
                legal_d = 1'b1;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_read = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                dest_d = rt;
            end
            OP_SW: begin
                legal_d = 1'b1;
                ctrl_d.alu_src = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            default: ;
        endcase
    end
    assign ctrl_s = ctrl_t'(ctrl_q);
    // Only R-type and sw consume rt as a source; I-type rt is a destination.
    assign reads_rt = opcode == OP_RTYPE || opcode == OP_SW;
    assign stall = valid_q && ctrl_s.mem_read && dest_q != 5'd0 &&
                   (dest_q == rs || (reads_rt && dest_q == rt));
    assign accept = warm_q == '0 && !stall;
    assign launch = accept && legal_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q    <= CW'(WARMUP);
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            warm_q    <= warm_q != '0 ? warm_q - CW'(1) : '0;
            valid_q   <= launch;
            illegal_q <= accept && !legal_d;
            pc_q      <= launch ? if_id_pc : '0;
            rs_data_q <= launch ? rs_data : '0;
            rt_data_q <= launch ? rt_data : '0;
            imm_q     <= launch ? imm_d : '0;
            shamt_q   <= launch ? if_id_instr[10:6] : '0;
            rs_q      <= launch ? rs : '0;
            rt_q      <= launch ? rt : '0;
            dest_q    <= launch ? dest_d : '0;
            ctrl_q    <= launch ? ctrl_d : '0;
        end
    end
    assign illegal          = illegal_q;
    assign id_ex_valid      = valid_q;
    assign id_ex_pc         = pc_q;
    assign id_ex_rs_data    = rs_data_q;
    assign id_ex_rt_data    = rt_data_q;
    assign id_ex_imm        = imm_q;
    assign id_ex_shamt      = shamt_q;
    assign id_ex_rs         = rs_q;
    assign id_ex_rt         = rt_q;
    assign id_ex_dest       = dest_q;
    assign id_ex_alu_op     = ctrl_s.alu_op;
    assign id_ex_alu_src    = ctrl_s.alu_src;
    assign id_ex_reg_write  = ctrl_s.reg_write;
    assign id_ex_mem_read   = ctrl_s.mem_read;
    assign id_ex_mem_write  = ctrl_s.mem_write;
    assign id_ex_mem_to_reg = ctrl_s.mem_to_reg;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vector table plus randomized run against a reference model of the ID stage.
module tb_instruction_decode;
    localparam int WARMUP = 2;
    localparam int PC_W = 10;
    localparam logic [5:0] FN_TAB [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    logic clk = 1'b0;
    logic reset, wb_we;
    logic [31:0] if_id_instr, wb_data;
    logic [PC_W-1:0] if_id_pc;
    logic [4:0] wb_addr;
    logic stall, illegal, id_ex_valid, id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic [PC_W-1:0] id_ex_pc;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0] id_ex_shamt, id_ex_rs, id_ex_rt, id_ex_dest;
    logic [3:0] id_ex_alu_op;

    always #5 clk = ~clk;

    instruction_decode #(.WARMUP(WARMUP), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .illegal(illegal),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs_data(id_ex_rs_data),
        .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_shamt(id_ex_shamt),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_dest(id_ex_dest), .id_ex_alu_op(id_ex_alu_op),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg)
    );

    typedef struct packed {
        logic valid, illegal;
        logic [PC_W-1:0] pc;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0] shamt, rs, rt, dest;
        logic [3:0] alu;
        logic src, rw, mr, mw, m2r;
    } out_t;

    typedef struct packed {
        logic rst;
        logic [31:0] ins;
        logic we;
        logic [4:0] wa;
        logic [31:0] wd;
        logic [2:0] e_flags;
        logic [4:0] e_dest;
        logic [3:0] e_alu;
        logic [4:0] e_ctrl;
        logic [31:0] e_rs, e_rt, e_imm;
    } vec_t;

    out_t act, cur;
    logic [31:0] mregs [32];
    int warm, checks, errors, ncyc;
    bit started;
    logic st_seen;
    vec_t tab [$];

    assign act = {id_ex_valid, illegal, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
                  id_ex_shamt, id_ex_rs, id_ex_rt, id_ex_dest, id_ex_alu_op, id_ex_alu_src,
                  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg};

    task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic bit m_stall(input logic [31:0] ins);
        bit rrt;
        rrt = ins[31:26] == 6'h00 || ins[31:26] == 6'h2B;
        return cur.valid && cur.mr && cur.dest != 5'd0 &&
               (cur.dest == ins[25:21] || (rrt && cur.dest == ins[20:16]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wa == r) return wd;
        return mregs[r];
    endfunction

    function automatic out_t m_next(input logic rst, input logic [31:0] ins, input logic we,
                                    input logic [4:0] wa, input logic [31:0] wd, input logic [PC_W-1:0] pc);
        out_t o;
        o = '0;
        if (rst || warm > 0 || m_stall(ins)) return o;
        case (ins[31:26])
            6'h00: begin
                for (int i = 0; i < 6; i++)
                    if (ins[5:0] == FN_TAB[i]) begin o.valid = 1'b1; o.alu = 4'(i); end
                o.rw = 1'b1;
                o.dest = ins[15:11];
            end
            6'h08: begin o.valid = 1'b1; o.src = 1'b1; o.rw = 1'b1; o.dest = ins[20:16]; end
            6'h23: begin o.valid = 1'b1; o.src = 1'b1; o.rw = 1'b1; o.mr = 1'b1; o.m2r = 1'b1; o.dest = ins[20:16]; end
            6'h2B: begin o.valid = 1'b1; o.src = 1'b1; o.mw = 1'b1; end
            default: ;
        endcase
        if (!o.valid) begin
            o = '0;
            o.illegal = 1'b1;
            return o;
        end
        o.pc = pc;
        o.rs_data = m_read(ins[25:21], we, wa, wd);
        o.rt_data = m_read(ins[20:16], we, wa, wd);
        o.imm = 32'($signed(ins[15:0]));
        o.shamt = ins[10:6];
        o.rs = ins[25:21];
        o.rt = ins[20:16];
        return o;
    endfunction

    task automatic cycle(input logic rst, input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [PC_W-1:0] pc);
        out_t nxt;
        reset = rst; if_id_instr = ins; wb_we = we; wb_addr = wa; wb_data = wd; if_id_pc = pc;
        #1;
        st_seen = stall;
        if (started) chk($sformatf("stall@%0d", ncyc), {159'd0, stall}, {159'd0, m_stall(ins)});
        nxt = m_next(rst, ins, we, wa, wd, pc);
        if (rst) begin
            warm = WARMUP;
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (warm > 0) warm--;
            if (we && wa != 5'd0) mregs[wa] = wd;
        end
        @(posedge clk);
        #1;
        cur = nxt;
        started = 1'b1;
        chk($sformatf("out@%0d", ncyc), {23'd0, act}, {23'd0, cur});
        ncyc++;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] rs, rt, rd;
        rs = 32'($urandom_range(0, 7)) << 21;
        rt = 32'($urandom_range(0, 7)) << 16;
        rd = 32'($urandom_range(0, 7)) << 11;
        case ($urandom_range(0, 9))
            0, 1, 2: return rs | rt | rd | (32'($urandom_range(0, 31)) << 6) | 32'(FN_TAB[$urandom_range(0, 5)]);
            3: return rs | rt | rd | 32'($urandom_range(0, 63));
            4: return 32'h2000_0000 | rs | rt | 32'($urandom_range(0, 65535));
            5, 9: return 32'h8C00_0000 | rs | rt | 32'($urandom_range(0, 65535));
            6: return 32'hAC00_0000 | rs | rt | 32'($urandom_range(0, 65535));
            7: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins_r, got;
        logic rst_r;
        bit hold;
        checks = 0; errors = 0; ncyc = 0; warm = 0; started = 1'b0; cur = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        // rst, instr, we, wa, wd, {stall,valid,illegal}, dest, alu, {src,rw,mr,mw,m2r}, rs_data, rt_data, imm
        tab.push_back('{1'b0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,    3'b000, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'hFC000000, 1'b0, 5'd0, 32'h0,    3'b000, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h20050064, 1'b1, 5'd5, 32'd100,  3'b010, 5'd5, 4'd0, 5'b11000, 32'h0,    32'h64,   32'h64});
        tab.push_back('{1'b0, 32'h00A53020, 1'b0, 5'd0, 32'h0,    3'b010, 5'd6, 4'd0, 5'b01000, 32'h64,   32'h64,   32'h3020});
        tab.push_back('{1'b0, 32'h00A53020, 1'b1, 5'd5, 32'h1234, 3'b010, 5'd6, 4'd0, 5'b01000, 32'h1234, 32'h1234, 32'h3020});
        tab.push_back('{1'b0, 32'h00001020, 1'b1, 5'd0, 32'hDEAD, 3'b010, 5'd2, 4'd0, 5'b01000, 32'h0,    32'h0,    32'h1020});
        tab.push_back('{1'b0, 32'h8C070000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd7, 4'd0, 5'b11101, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00E04020, 1'b1, 5'd7, 32'h55,   3'b100, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00E04020, 1'b0, 5'd0, 32'h0,    3'b010, 5'd8, 4'd0, 5'b01000, 32'h55,   32'h0,    32'h4020});
        tab.push_back('{1'b0, 32'h8C070000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd7, 4'd0, 5'b11101, 32'h0,    32'h55,   32'h0});
        tab.push_back('{1'b0, 32'hAC070004, 1'b0, 5'd0, 32'h0,    3'b100, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'hAC070004, 1'b0, 5'd0, 32'h0,    3'b010, 5'd0, 4'd0, 5'b10010, 32'h0,    32'h55,   32'h4});
        tab.push_back('{1'b0, 32'h2005FFFC, 1'b0, 5'd0, 32'h0,    3'b010, 5'd5, 4'd0, 5'b11000, 32'h0,    32'h1234, 32'hFFFFFFFC});
        tab.push_back('{1'b0, 32'hFC000000, 1'b0, 5'd0, 32'h0,    3'b001, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00000000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd0, 4'd5, 5'b01000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h8C000000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd0, 4'd0, 5'b11101, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00000000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd0, 4'd5, 5'b01000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b1, 32'h20050064, 1'b0, 5'd0, 32'h0,    3'b000, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00A53020, 1'b0, 5'd0, 32'h0,    3'b000, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00A53020, 1'b0, 5'd0, 32'h0,    3'b000, 5'd0, 4'd0, 5'b00000, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h00A53020, 1'b0, 5'd0, 32'h0,    3'b010, 5'd6, 4'd0, 5'b01000, 32'h0,    32'h0,    32'h3020});
        tab.push_back('{1'b0, 32'h8C070000, 1'b0, 5'd0, 32'h0,    3'b010, 5'd7, 4'd0, 5'b11101, 32'h0,    32'h0,    32'h0});
        tab.push_back('{1'b0, 32'h20070001, 1'b0, 5'd0, 32'h0,    3'b010, 5'd7, 4'd0, 5'b11000, 32'h0,    32'h0,    32'h1});
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, '0);
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, '0);
        foreach (tab[i]) begin
            cycle(tab[i].rst, tab[i].ins, tab[i].we, tab[i].wa, tab[i].wd, PC_W'(i * 4));
            chk($sformatf("vec%0d", i),
                {31'd0, st_seen, id_ex_valid, illegal, id_ex_dest, id_ex_alu_op, id_ex_alu_src, id_ex_reg_write,
                 id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_rs_data, id_ex_rt_data, id_ex_imm},
                {31'd0, tab[i].e_flags, tab[i].e_dest, tab[i].e_alu, tab[i].e_ctrl, tab[i].e_rs, tab[i].e_rt, tab[i].e_imm});
        end
        ins_r = 32'h0;
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) ins_r = gen();
            rst_r = $urandom_range(0, 99) == 0;
            hold = m_stall(ins_r) && !rst_r;
            got = $urandom;
            cycle(rst_r, ins_r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), got, PC_W'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
